// File: rtl/add_code_encoder.sv
// Add-code to nibble encoder: legal codes 1..4 become {class, seq} nibbles queued in a
// small FIFO; illegal codes are consumed, flagged for one cycle and counted.
module add_code_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               add_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_pulse,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [3:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [1:0]       seq_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic       legal, accept, push, bad, pop;
  logic [1:0] cls;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign legal     = (add_in >= 3'd1) && (add_in <= 3'd4);
  // Codes 1..4 map to classes 0..3; the low two bits minus one wrap 4 onto 3.
  assign cls       = add_in[1:0] - 2'd1;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign bad       = accept && !legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      seq_q       <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      level_q     <= level_d;
      err_pulse_q <= bad;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        seq_q    <= seq_q + 2'd1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      if (bad && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only visible once level covers them.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem_q[wr_ptr_q] <= {cls, seq_q};
  end

  assign data_out  = mem_q[rd_ptr_q];
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign level     = level_q;
endmodule

// File: tb/tb_add_code_encoder.sv
// Bench for add_code_encoder: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_add_code_encoder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] add_in;
  logic       in_valid, out_ready;

  logic       in_ready, out_valid, err_pulse;
  logic [3:0] data_out;
  logic [7:0] err_cnt;
  logic [2:0] level;

  logic       s_in_ready, s_out_valid, s_err_pulse;
  logic [3:0] s_data_out;
  logic [1:0] s_err_cnt;
  logic [2:0] s_level;

  int checks = 0;
  int errors = 0;

  add_code_encoder #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .add_in(add_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .level(level)
  );

  add_code_encoder #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .add_in(add_in), .in_valid(in_valid), .in_ready(s_in_ready),
    .data_out(s_data_out), .out_valid(s_out_valid), .out_ready(out_ready),
    .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .level(s_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of nibbles, a sequence number and an unbounded error tally.
  logic [3:0] m_q[$];
  int  m_seq = 0;
  int  m_err = 0;
  bit  m_pulse = 0;
  bit  armed = 0;
  bit  m_acc, m_pop, m_legal;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_seq = 0; m_err = 0; m_pulse = 0; armed = 1;
    end else if (armed) begin
      m_acc   = in_valid && (m_q.size() < DEPTH);
      m_pop   = out_ready && (m_q.size() > 0);
      m_legal = (add_in >= 1) && (add_in <= 4);
      m_pulse = m_acc && !m_legal;
      if (m_pop) void'(m_q.pop_front());
      if (m_acc && m_legal) begin
        m_q.push_back(4'((int'(add_in) - 1) * 4 + m_seq));
        m_seq = (m_seq + 1) % 4;
      end
      if (m_acc && !m_legal) m_err++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready",  int'(in_ready),  int'(m_q.size() != DEPTH));
      chk("out_valid", int'(out_valid), int'(m_q.size() != 0));
      chk("level",     int'(level),     m_q.size());
      chk("err_pulse", int'(err_pulse), int'(m_pulse));
      chk("err_cnt",   int'(err_cnt),   sat(m_err, 255));
      chk("s_level",     int'(s_level),     m_q.size());
      chk("s_err_pulse", int'(s_err_pulse), int'(m_pulse));
      chk("s_err_cnt",   int'(s_err_cnt),   sat(m_err, 3));
      if (m_q.size() != 0) begin
        chk("data_out",   int'(data_out),   int'(m_q[0]));
        chk("s_data_out", int'(s_data_out), int'(m_q[0]));
      end
    end
  end

  task automatic step(input bit v, input int c, input bit r);
    in_valid  = v;
    add_in    = 3'(c);
    out_ready = r;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
  endtask

  // Literal head check on both the DUT and the model, so the model is pinned too.
  task automatic head(input string nm, input int exp);
    chk({nm, "_dut"}, int'(data_out), exp);
    if (m_q.size() != 0) chk({nm, "_model"}, int'(m_q[0]), exp);
    else chk({nm, "_model_empty"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; add_in = '0; out_ready = 1'b0;
    @(negedge clk); #1;
    do_reset();
    chk("rst_level", int'(level), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);

    // Streaming codes 1..4 straight through
    step(1, 1, 1); head("t1_a", 4'b0000); chk("t1_lvl_a", int'(level), 1);
    step(1, 2, 1); head("t1_b", 4'b0101); chk("t1_lvl_b", int'(level), 1);
    step(1, 3, 1); head("t1_c", 4'b1010); chk("t1_lvl_c", int'(level), 1);
    step(1, 4, 1); head("t1_d", 4'b1111); chk("t1_lvl_d", int'(level), 1);
    step(0, 0, 1); chk("t1_empty", int'(level), 0);

    // Fill to full, hold off the fifth, then drain
    for (int i = 0; i < 4; i++) step(1, 2, 0);
    chk("t2_full_lvl", int'(level), 4);
    chk("t2_full_rdy", int'(in_ready), 0);
    step(1, 2, 0);
    chk("t2_held_lvl", int'(level), 4); head("t2_h0", 4'b0100);
    step(1, 2, 1);
    chk("t2_nobypass_lvl", int'(level), 3); head("t2_h1", 4'b0101);
    step(1, 2, 1);
    chk("t2_pushpop_lvl", int'(level), 3); head("t2_h2", 4'b0110);
    step(0, 0, 1); head("t2_h3", 4'b0111);
    step(0, 0, 1); head("t2_h4", 4'b0100); chk("t2_lvl1", int'(level), 1);
    step(0, 0, 1); chk("t2_empty", int'(level), 0);

    // Illegal codes between legal ones
    do_reset();
    step(1, 0, 1); chk("t3_p0", int'(err_pulse), 1); chk("t3_c0", int'(err_cnt), 1);
    step(1, 5, 1); chk("t3_p1", int'(err_pulse), 1); chk("t3_c1", int'(err_cnt), 2);
    step(1, 7, 1); chk("t3_p2", int'(err_pulse), 1); chk("t3_c2", int'(err_cnt), 3);
    chk("t3_lvl_err", int'(level), 0);
    step(1, 3, 1); chk("t3_p3", int'(err_pulse), 0); head("t3_h", 4'b1000);
    step(0, 0, 1); chk("t3_empty", int'(level), 0);

    // Narrow counter saturation
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1, 6, 1);
      chk("t4_pulse", int'(s_err_pulse), 1);
      chk("t4_cnt", int'(s_err_cnt), (i > 3) ? 3 : i);
    end
    step(0, 0, 1); chk("t4_pulse_end", int'(s_err_pulse), 0);

    // Reset mid-operation with a handshake in the same cycle
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    chk("t6_lvl3", int'(level), 3);
    step(1, 6, 0);
    rst = 1'b1; step(1, 1, 1); rst = 1'b0;
    chk("t6_lvl", int'(level), 0);
    chk("t6_ov", int'(out_valid), 0);
    chk("t6_err", int'(err_cnt), 0);
    step(1, 1, 1); head("t6_h", 4'b0000);

    // Randomized soak with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 2) != 0);
    end
    rst = 1'b0;

    // Wide counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) step(1, 0, $urandom_range(0, 1) != 0);
    chk("sat_main", int'(err_cnt), 255);
    chk("sat_small", int'(s_err_cnt), 3);
    step(0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_code_encoder.md
Name: add_code_encoder

Overview:
- Reverse-direction companion to the nibble classifier in this design. It takes 3-bit add codes (1..4) and regenerates 4-bit data nibbles that the classifier maps back to the same code.
- Upper two bits of each nibble carry the code class. Lower two "don't-care" bits come from a rolling sequence counter.
- Valid/ready handshakes and a small FIFO decouple the producer from the consumer. Illegal codes are dropped and counted.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
add_in  input  3  code to encode; legal values 1..4
in_valid  input  1  add_in is valid this cycle
in_ready  output  1  block can accept add_in this cycle
data_out  output  4  encoded nibble at FIFO head
out_valid  output  1  data_out is valid
out_ready  input  1  consumer accepts data_out this cycle
err_pulse  output  1  one-cycle pulse: an illegal code was accepted last cycle
err_cnt  output  CNT_W  count of illegal codes accepted, saturating
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO is emptied: level=0, out_valid=0, in_ready=1 after the edge.
  - Sequence counter=0, err_pulse=0, err_cnt=0.
  - data_out is don't-care while out_valid=0; the bench must not check it.
  - Reset mid-operation discards all queued entries, and any handshake in that same cycle is ignored.
- Accept: occurs when in_valid && in_ready. in_ready = (level != DEPTH).
  - in_ready depends only on occupancy. There is no bypass: a pop in the same cycle does not free space for a push when full.
- Encoding for a legal code c in 1..4:
  - push {c-1 (2 bits), seq (2 bits)}.
  - Examples: c=1 gives 4'b00ss, c=2 gives 01ss, c=3 gives 10ss, c=4 gives 11ss.
- Sequence counter:
  - seq is a 2-bit counter that increments only on a legal push and wraps 3 to 0.
  - Illegal accepts and pops do not change seq.
- Illegal codes (0, 5, 6, 7):
  - Accepted (consume the handshake) but not pushed; level is unchanged.
  - err_pulse=1 in the following cycle only.
  - err_cnt increments by 1 and holds at 2^CNT_W-1 once saturated.
  - Back-to-back illegal accepts give err_pulse high for consecutive cycles.
- Pop: occurs when out_valid && out_ready. out_valid = (level != 0). data_out = mem[rd_ptr], taken from registers with no combinational path from inputs.
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. Throughput is one nibble per cycle.
- Simultaneous push and pop (level between 1 and DEPTH-1): level is unchanged and both pointers advance.
- Pop with an illegal accept in the same cycle: level decrements.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally. Full/empty is determined by level, not by pointer comparison.
- Stability: data_out and out_valid hold stable while out_valid=1 and out_ready=0.

Test Plan:
1. Reset, then push codes 1, 2, 3, 4 with out_ready=1 -> data_out sequence 4'b0000, 4'b0101, 4'b1010, 4'b1111. Each appears 1 cycle after its push; level never exceeds 1.
2. out_ready=0, push 5 legal codes of value 2 with DEPTH=4:
   - in_ready drops after the 4th accept; level=4.
   - The 5th is held off.
   - Then raise out_ready -> pops give 0100, 0101, 0110, 0111. The 5th push completes and gives 0100 (seq wrapped).
3. Push codes 0, 5, 7, 3 -> err_pulse high on 3 consecutive cycles, err_cnt=3. Only one entry (4'b1000) is output; seq is unaffected by the illegal codes.
4. With CNT_W=2, push 5 illegal codes -> err_cnt reaches 3 and holds at 3; err_pulse still fires 5 times.
5. FIFO full, in_valid=1, out_ready=1 for one cycle -> the pop occurs, no push that cycle (in_ready=0), level=3. The push occurs on the next cycle, level=4.
6. With 3 entries queued, assert rst for one cycle while in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, err_cnt=0. The next legal code 1 gives data_out=4'b0000.
